// File: rtl/gomoku_game_core_if.sv
// Gomoku core bus: player controls, renderer read port and game status.
//   master : drives move_l/r/u/d, select, restart, rd_x, rd_y; observes the rest
//   slave  : the game core
// Handshake: there is no valid/ready pair on this bus. Control inputs are
// single-cycle pulses sampled on the rising clock edge, and rd_cell always
// reflects the (rd_x, rd_y) that was presented on the previous edge.
interface gomoku_game_core_if #(
  parameter int N = 15
);
  localparam int CW = $clog2(N);

  logic              move_l;
  logic              move_r;
  logic              move_u;
  logic              move_d;
  logic              select;
  logic              restart;
  logic [CW-1:0]     rd_x;
  logic [CW-1:0]     rd_y;
  logic [1:0]        rd_cell;
  logic [CW-1:0]     cursor_x;
  logic [CW-1:0]     cursor_y;
  logic [CW-1:0]     last_x;
  logic [CW-1:0]     last_y;
  logic              player_turn;
  logic [1:0]        winner;
  logic              game_over;
  logic              busy;
  logic [2*CW-1:0]   move_count;
  logic [1:0]        dbg_state;

  modport master (
    output move_l, move_r, move_u, move_d, select, restart, rd_x, rd_y,
    input  rd_cell, cursor_x, cursor_y, last_x, last_y, player_turn,
           winner, game_over, busy, move_count, dbg_state
  );

  modport slave (
    input  move_l, move_r, move_u, move_d, select, restart, rd_x, rd_y,
    output rd_cell, cursor_x, cursor_y, last_x, last_y, player_turn,
           winner, game_over, busy, move_count, dbg_state
  );
endinterface

// File: rtl/gomoku_game_core.sv
// N x N Gomoku engine: board store, cursor, turn, win/draw detection and
// board clearing, plus one registered cell read port for the renderer.
// Win detection walks rays outward from the last stone, one probe per cycle.
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   game_if  gomoku_game_core_if.slave (controls, read port, status, dbg_state)
module gomoku_game_core #(
  parameter int N       = 15,
  parameter int WIN_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  gomoku_game_core_if.slave       game_if
);
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(N * N);
  localparam int KW = $clog2(WIN_LEN + 1);

  localparam logic [CW-1:0]        CENTER = CW'(N / 2);
  localparam logic [CW-1:0]        MAXC   = CW'(N - 1);
  localparam logic [CW:0]          NU     = (CW + 1)'(N);
  localparam logic [2*CW-1:0]      FULL   = (2 * CW)'(N * N);
  localparam logic [IW-1:0]        LASTI  = IW'(N * N - 1);
  localparam logic [KW-1:0]        KMAX   = KW'(WIN_LEN - 1);
  localparam logic [KW-1:0]        WINK   = KW'(WIN_LEN);
  // Probe coordinates carry two extra bits so -1 and N are representable.
  localparam logic signed [CW+1:0] ZERO   = '0;
  localparam logic signed [CW+1:0] ONE    = (CW + 2)'(1);
  localparam logic signed [CW+1:0] NEG    = -ONE;
  localparam logic signed [CW+1:0] NS     = (CW + 2)'(N);

  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER, S_CLEAR} state_t;

  // Axis order: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
  function automatic logic signed [CW+1:0] step_x(input logic [1:0] axis);
    return (axis == 2'd1) ? ZERO : ONE;
  endfunction

  function automatic logic signed [CW+1:0] step_y(input logic [1:0] axis);
    case (axis)
      2'd0:    return ZERO;
      2'd3:    return NEG;
      default: return ONE;
    endcase
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return IW'(y) * IW'(N) + IW'(x);
  endfunction

  // inc/dec in the same cycle cancel out.
  function automatic logic [CW-1:0] wrap_step(input logic [CW-1:0] v, input logic inc, input logic dec);
    if (inc && !dec) return (v == MAXC) ? '0 : v + CW'(1);
    if (dec && !inc) return (v == '0) ? MAXC : v - CW'(1);
    return v;
  endfunction

  logic [1:0]              board_q [N*N];
  state_t                  state_q, state_d;
  logic [CW-1:0]           cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CW-1:0]           last_x_q, last_x_d, last_y_q, last_y_d;
  logic                    turn_q, turn_d;
  logic [1:0]              winner_q, winner_d;
  logic [2*CW-1:0]         count_q, count_d;
  logic [1:0]              rd_cell_q;
  logic [1:0]              axis_q, axis_d;
  logic                    dir_q, dir_d;           // 0: + ray, 1: - ray
  logic [KW-1:0]           k_q, k_d;               // probe distance on this ray
  logic [KW-1:0]           run_q, run_d;           // stones in line on this axis
  logic signed [CW+1:0]    px_q, px_d, py_q, py_d; // current probe position
  logic                    done_q, done_d, won_q, won_d;
  logic [IW-1:0]           clr_q, clr_d;

  logic                    we_place, we_clear, ray_end, p_inb, p_match, rd_inb;
  logic [1:0]              colour, cur_cell, p_cell;
  logic [IW-1:0]           cur_idx, p_idx, rd_idx;
  logic [KW-1:0]           run_nx;
  logic [1:0]              axis_nx;
  logic signed [CW+1:0]    lx_s, ly_s, cx_s, cy_s, dx, dy;

  assign colour   = {turn_q, ~turn_q};
  assign cur_idx  = cell_idx(cur_x_q, cur_y_q);
  assign cur_cell = board_q[cur_idx];
  assign lx_s     = $signed({2'b00, last_x_q});
  assign ly_s     = $signed({2'b00, last_y_q});
  assign cx_s     = $signed({2'b00, cur_x_q});
  assign cy_s     = $signed({2'b00, cur_y_q});
  assign dx       = dir_q ? -step_x(axis_q) : step_x(axis_q);
  assign dy       = dir_q ? -step_y(axis_q) : step_y(axis_q);
  assign axis_nx  = axis_q + 2'd1;
  assign run_nx   = run_q + KW'(1);

  assign p_inb   = (px_q >= ZERO) && (px_q < NS) && (py_q >= ZERO) && (py_q < NS);
  assign p_idx   = cell_idx(px_q[CW-1:0], py_q[CW-1:0]);
  assign p_cell  = p_inb ? board_q[p_idx] : 2'd0;
  assign p_match = p_inb && (p_cell == colour);

  assign rd_inb  = ({1'b0, game_if.rd_x} < NU) && ({1'b0, game_if.rd_y} < NU);
  assign rd_idx  = cell_idx(game_if.rd_x, game_if.rd_y);

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    count_d  = count_q;
    axis_d   = axis_q;
    dir_d    = dir_q;
    k_d      = k_q;
    run_d    = run_q;
    px_d     = px_q;
    py_d     = py_q;
    done_d   = done_q;
    won_d    = won_q;
    clr_d    = clr_q;
    we_place = 1'b0;
    we_clear = 1'b0;
    ray_end  = 1'b0;

    case (state_q)
      S_PLAY: begin
        cur_x_d = wrap_step(cur_x_q, game_if.move_r, game_if.move_l);
        cur_y_d = wrap_step(cur_y_q, game_if.move_d, game_if.move_u);
        // Placement uses the pre-move cursor even if a move arrives together.
        if (game_if.select && (cur_cell == 2'd0)) begin
          we_place = 1'b1;
          last_x_d = cur_x_q;
          last_y_d = cur_y_q;
          count_d  = count_q + (2 * CW)'(1);
          state_d  = S_CHECK;
          axis_d   = 2'd0;
          dir_d    = 1'b0;
          k_d      = KW'(1);
          run_d    = KW'(1);
          done_d   = 1'b0;
          won_d    = 1'b0;
          px_d     = cx_s + ONE;
          py_d     = cy_s;
        end
      end

      S_CHECK: begin
        if (done_q) begin
          // Exit cycle: resolve the scan result.
          if (won_q) begin
            winner_d = colour;
            state_d  = S_OVER;
          end else if (count_q == FULL) begin
            winner_d = 2'd3;
            state_d  = S_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_PLAY;
          end
        end else begin
          if (p_match) begin
            run_d = run_nx;
            if (run_nx >= WINK) begin
              won_d  = 1'b1;
              done_d = 1'b1;
            end else if (k_q == KMAX) begin
              ray_end = 1'b1;
            end else begin
              k_d  = k_q + KW'(1);
              px_d = px_q + dx;
              py_d = py_q + dy;
            end
          end else begin
            ray_end = 1'b1;
          end

          if (ray_end) begin
            if (!dir_q) begin
              dir_d = 1'b1;
              k_d   = KW'(1);
              px_d  = lx_s - step_x(axis_q);
              py_d  = ly_s - step_y(axis_q);
            end else if (axis_q == 2'd3) begin
              done_d = 1'b1;
            end else begin
              axis_d = axis_nx;
              dir_d  = 1'b0;
              k_d    = KW'(1);
              run_d  = KW'(1);
              px_d   = lx_s + step_x(axis_nx);
              py_d   = ly_s + step_y(axis_nx);
            end
          end
        end
      end

      S_OVER: ;

      S_CLEAR: begin
        we_clear = 1'b1;
        clr_d    = clr_q + IW'(1);
        if (clr_q == LASTI) state_d = S_PLAY;
      end

      default: state_d = S_PLAY;
    endcase

    // New game: from OVER on select, or from anywhere on restart.
    if (game_if.restart || ((state_q == S_OVER) && game_if.select)) begin
      state_d  = S_CLEAR;
      clr_d    = '0;
      winner_d = 2'd0;
      count_d  = '0;
      turn_d   = 1'b0;
      cur_x_d  = CENTER;
      cur_y_d  = CENTER;
      we_place = 1'b0;
      we_clear = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_PLAY;
      cur_x_q  <= CENTER;
      cur_y_q  <= CENTER;
      last_x_q <= '0;
      last_y_q <= '0;
      turn_q   <= 1'b0;
      winner_q <= 2'd0;
      count_q  <= '0;
      axis_q   <= 2'd0;
      dir_q    <= 1'b0;
      k_q      <= '0;
      run_q    <= '0;
      px_q     <= ZERO;
      py_q     <= ZERO;
      done_q   <= 1'b0;
      won_q    <= 1'b0;
      clr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      last_x_q <= last_x_d;
      last_y_q <= last_y_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      count_q  <= count_d;
      axis_q   <= axis_d;
      dir_q    <= dir_d;
      k_q      <= k_d;
      run_q    <= run_d;
      px_q     <= px_d;
      py_q     <= py_d;
      done_q   <= done_d;
      won_q    <= won_d;
      clr_q    <= clr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N * N; i++) board_q[i] <= 2'd0;
    end else if (we_place) begin
      board_q[cur_idx] <= colour;
    end else if (we_clear) begin
      board_q[clr_q] <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_cell_q <= 2'd0;
    else     rd_cell_q <= rd_inb ? board_q[rd_idx] : 2'd0;
  end

  assign game_if.rd_cell     = rd_cell_q;
  assign game_if.cursor_x    = cur_x_q;
  assign game_if.cursor_y    = cur_y_q;
  assign game_if.last_x      = last_x_q;
  assign game_if.last_y      = last_y_q;
  assign game_if.player_turn = turn_q;
  assign game_if.winner      = winner_q;
  assign game_if.game_over   = (winner_q != 2'd0);
  assign game_if.busy        = (state_q == S_CHECK) || (state_q == S_CLEAR);
  assign game_if.move_count  = count_q;
  assign game_if.dbg_state   = state_q;
endmodule
